data_mem_arbiter: RTL and testbench

Shares the single-ported 256×8 data memory between two requesters:
- the CPU controller's load/store states;
- a host/test loader that preloads and inspects data memory.

Each accepted request becomes a fixed SETUP/STROBE/RESP sequence on the memory's level-sensitive enables, so address and data are stable before any enable edge. Read data comes back to the requester that owned the access.

---
 rtl/data_mem_arb_pkg.sv | 18 +
 rtl/data_mem_arbiter_rr_arb2.sv | 28 ++
 rtl/data_mem_arbiter.sv | 138 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, requester IDs, widths.
package data_mem_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    // Requester IDs, also used as bit positions in the req/grant vectors.
    localparam bit REQ_CPU  = 1'b0;
    localparam bit REQ_HOST = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/data_mem_arbiter_rr_arb2.sv
// Two-input pick: round-robin on a tie, or host-wins-tie when HOST_PRIORITY is set.
import data_mem_arb_pkg::*;

module rr_arb2 #(
    parameter bit HOST_PRIORITY = 1'b0
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant; a lone request always wins, a tie goes to whoever was not served last.
    always_comb begin
        grant = 2'b00;
        if (req[REQ_CPU] && req[REQ_HOST]) begin
            if (HOST_PRIORITY || (last == REQ_CPU)) begin
                grant[REQ_HOST] = 1'b1;
            end else begin
                grant[REQ_CPU] = 1'b1;
            end
        end else if (req[REQ_CPU]) begin
            grant[REQ_CPU] = 1'b1;
        end else if (req[REQ_HOST]) begin
            grant[REQ_HOST] = 1'b1;
        end
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares the 256x8 data memory between CPU and host with a fixed
// SETUP/STROBE/RESP access so address and data settle before any enable edge.
//
// Handshake: a request transfers on a rising edge where X_req && X_ready.
// ready is combinational, high only in IDLE for the arbitration winner; all
// request fields are latched at that edge, so the requester may change them
// afterwards. Requests seen outside IDLE are ignored.
import data_mem_arb_pkg::*;

module data_mem_arbiter #(
    parameter bit HOST_PRIORITY = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_done,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_ready,
    output logic              host_done,
    output logic [DATA_W-1:0] host_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    arb_state_t        state_q, state_d;
    logic [1:0]        grant;
    logic              accept;
    logic              owner_q;
    logic              we_q;
    logic              last_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    rr_arb2 #(.HOST_PRIORITY(HOST_PRIORITY)) u_arb (
        .req   ({host_req, cpu_req}),
        .last  (last_q),
        .grant (grant)
    );

    assign accept    = (state_q == ST_IDLE) && (grant != 2'b00);
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign dbg_state = state_q;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fixed four-cycle walk once an access is accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Outputs: enables only in STROBE, done only in RESP, ready only in IDLE out of reset.
    always_comb begin
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;
        cpu_done         = 1'b0;
        host_done        = 1'b0;
        busy             = (state_q != ST_IDLE);
        cpu_ready        = reset_n && (state_q == ST_IDLE) && grant[REQ_CPU];
        host_ready       = reset_n && (state_q == ST_IDLE) && grant[REQ_HOST];
        case (state_q)
            ST_STROBE: begin
                mem_write_enable = we_q;
                mem_read_enable  = !we_q;
            end
            ST_RESP: begin
                cpu_done  = (owner_q == REQ_CPU);
                host_done = (owner_q == REQ_HOST);
            end
            default: ;
        endcase
    end

    // Latch the winning request at the accept edge; mem_addr/mem_wdata hold until the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_q <= REQ_CPU;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            last_q  <= REQ_HOST;
        end else if (accept) begin
            owner_q <= grant[REQ_HOST];
            last_q  <= grant[REQ_HOST];
            if (grant[REQ_HOST]) begin
                we_q    <= host_we;
                addr_q  <= host_addr;
                wdata_q <= host_wdata;
            end else begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
        end
    end

    // Capture read data for the owner only, on the STROBE->RESP edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cpu_rdata  <= '0;
            host_rdata <= '0;
        end else if ((state_q == ST_STROBE) && !we_q) begin
            if (owner_q == REQ_HOST) begin
                host_rdata <= mem_rdata;
            end else begin
                cpu_rdata <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: round-robin and host-priority instances share stimulus,
// each backed by its own memory model.
module tb_data_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cpu_req = 1'b0, cpu_we = 1'b0, host_req = 1'b0, host_we = 1'b0;
    logic [7:0] cpu_addr = '0, cpu_wdata = '0, host_addr = '0, host_wdata = '0;

    logic       cr0, cd0, hr0, hd0, we0, re0, busy0;
    logic [7:0] crd0, hrd0, maddr0, mwd0, mrd0;
    logic [1:0] st0;
    logic       cr1, cd1, hr1, hd1, we1, re1, busy1;
    logic [7:0] crd1, hrd1, maddr1, mwd1, mrd1;
    logic [1:0] st1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    int vec_count = 0;
    int fail_count = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(.HOST_PRIORITY(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cr0), .cpu_done(cd0), .cpu_rdata(crd0),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(hr0), .host_done(hd0), .host_rdata(hrd0),
        .mem_addr(maddr0), .mem_wdata(mwd0), .mem_write_enable(we0), .mem_read_enable(re0),
        .mem_rdata(mrd0), .busy(busy0), .dbg_state(st0)
    );

    data_mem_arbiter #(.HOST_PRIORITY(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cr1), .cpu_done(cd1), .cpu_rdata(crd1),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_ready(hr1), .host_done(hd1), .host_rdata(hrd1),
        .mem_addr(maddr1), .mem_wdata(mwd1), .mem_write_enable(we1), .mem_read_enable(re1),
        .mem_rdata(mrd1), .busy(busy1), .dbg_state(st1)
    );

    // Memory models: combinational read, write on the clock while the strobe is high.
    assign mrd0 = mem0[maddr0];
    assign mrd1 = mem1[maddr1];
    always @(posedge clk) if (we0) mem0[maddr0] <= mwd0;
    always @(posedge clk) if (we1) mem1[maddr1] <= mwd1;

    // Packed observation: {cready, hready, wen, ren, cdone, hdone, busy, mem_addr, cpu_rdata, host_rdata}
    logic [30:0] act0, act1;
    assign act0 = {cr0, hr0, we0, re0, cd0, hd0, busy0, maddr0, crd0, hrd0};
    assign act1 = {cr1, hr1, we1, re1, cd1, hd1, busy1, maddr1, crd1, hrd1};

    function automatic logic [30:0] mk(input logic cr, hr, we, re, cd, hd, bz,
                                       input logic [7:0] a, crd, hrd);
        return {cr, hr, we, re, cd, hd, bz, a, crd, hrd};
    endfunction

    typedef struct {
        logic        cr, cw;
        logic [7:0]  ca, cd;
        logic        hr, hw;
        logic [7:0]  ha, hd;
        logic [30:0] exp;
    } vec_t;

    vec_t vecs [17];

    task automatic check(input string name, input logic [30:0] act, input logic [30:0] exp);
        vec_count++;
        if (act !== exp) begin
            fail_count++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, cw, input logic [7:0] ca, cd,
                         input logic hr, hw, input logic [7:0] ha, hd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [30:0] e;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = 8'h00;
            mem1[i] = 8'h00;
        end

        // CPU write 5A @10, read it back, then host write 33 @20 and read it back.
        vecs[0]  = '{1,1,8'h10,8'h5A, 0,0,8'h00,8'h00, mk(1,0,0,0,0,0,0,8'h00,8'h00,8'h00)};
        vecs[1]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,0,0,0,1,8'h10,8'h00,8'h00)};
        vecs[2]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,1,0,0,0,1,8'h10,8'h00,8'h00)};
        vecs[3]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,0,1,0,1,8'h10,8'h00,8'h00)};
        vecs[4]  = '{1,0,8'h10,8'h00, 0,0,8'h00,8'h00, mk(1,0,0,0,0,0,0,8'h10,8'h00,8'h00)};
        vecs[5]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,0,0,0,1,8'h10,8'h00,8'h00)};
        vecs[6]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,1,0,0,1,8'h10,8'h00,8'h00)};
        vecs[7]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,0,1,0,1,8'h10,8'h5A,8'h00)};
        vecs[8]  = '{0,0,8'h00,8'h00, 1,1,8'h20,8'h33, mk(0,1,0,0,0,0,0,8'h10,8'h5A,8'h00)};
        vecs[9]  = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,0,0,0,1,8'h20,8'h5A,8'h00)};
        vecs[10] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,1,0,0,0,1,8'h20,8'h5A,8'h00)};
        vecs[11] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,0,0,1,1,8'h20,8'h5A,8'h00)};
        vecs[12] = '{0,0,8'h00,8'h00, 1,0,8'h20,8'h00, mk(0,1,0,0,0,0,0,8'h20,8'h5A,8'h00)};
        vecs[13] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,0,0,0,1,8'h20,8'h5A,8'h00)};
        vecs[14] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,1,0,0,1,8'h20,8'h5A,8'h00)};
        vecs[15] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,0,0,1,1,8'h20,8'h5A,8'h33)};
        vecs[16] = '{0,0,8'h00,8'h00, 0,0,8'h00,8'h00, mk(0,0,0,0,0,0,0,8'h20,8'h5A,8'h33)};

        // Reset held with a pending CPU request: everything quiet, no ready.
        drive(1,0,8'h00,8'h00, 0,0,8'h00,8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("reset_hold_rr", act0, '0);
        check("reset_hold_hp", act1, '0);
        check("reset_state", {29'd0, st0}, {29'd0, 2'd0});
        reset_n = 1'b1;
        #1;
        check("reset_release_ready", act0, mk(1,0,0,0,0,0,0,8'h00,8'h00,8'h00));
        cpu_req = 1'b0;

        // Table-driven single-requester accesses on the round-robin instance.
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
                  vecs[i].hr, vecs[i].hw, vecs[i].ha, vecs[i].hd);
            #1;
            check($sformatf("vec%0d", i), act0, vecs[i].exp);
        end

        // Continuous tie: RR alternates CPU/host starting with CPU; HP always picks host.
        @(negedge clk);
        drive(1,0,8'h10,8'h00, 1,0,8'h20,8'h00);
        for (int c = 0; c < 16; c++) begin
            logic ph0, grp_odd;
            ph0 = (c % 4 == 0);
            grp_odd = ((c / 4) % 2 == 1);
            #1;
            e = {ph0 && !grp_odd, ph0 && grp_odd, 1'b0, (c % 4 == 2),
                 (c % 4 == 3) && !grp_odd, (c % 4 == 3) && grp_odd, !ph0, 23'd0};
            check($sformatf("tie_rr_c%0d", c), {act0[30:24], 23'd0}, e);
            e = {1'b0, ph0, 1'b0, (c % 4 == 2), 1'b0, (c % 4 == 3), !ph0, 23'd0};
            check($sformatf("tie_hp_c%0d", c), {act1[30:24], 23'd0}, e);
            @(negedge clk);
        end
        host_req = 1'b0;
        #1;
        check("hp_cpu_after_host_drops", {act1[30:24], 23'd0}, {7'b1000000, 23'd0});
        cpu_req = 1'b0;

        // Mid-operation reset during the strobe of a host write to FF.
        @(negedge clk);
        drive(0,0,8'h00,8'h00, 1,1,8'hFF,8'hC3);
        @(negedge clk);
        host_req = 1'b0;
        @(negedge clk); #1;
        check("midrst_strobe", {act0[30:24], act0[23:16], 16'd0},
              {7'b0010001, 8'hFF, 16'd0});
        reset_n = 1'b0;
        #1;
        check("midrst_drop", {act0[30:24], 24'd0}, '0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("midrst_after_c%0d", c), {act0[30:24], 22'd0, st0}, '0);
            @(negedge clk);
        end

        // Late change: address changes and req drops during SETUP; original address is used.
        drive(1,1,8'h30,8'h77, 0,0,8'h00,8'h00);
        #1;
        check("late_accept", {act0[30:24], 24'd0}, {7'b1000000, 24'd0});
        @(negedge clk);
        cpu_addr = 8'h31;
        cpu_req = 1'b0;
        #1;
        check("late_setup", {act0[30:24], act0[23:16], 16'd0}, {7'b0000001, 8'h30, 16'd0});
        @(negedge clk); #1;
        check("late_strobe", {act0[30:24], act0[23:16], 16'd0}, {7'b0010001, 8'h30, 16'd0});
        @(negedge clk); #1;
        check("late_resp", {act0[30:24], act0[23:16], 16'd0}, {7'b0000101, 8'h30, 16'd0});
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); #1;
            check($sformatf("late_idle_c%0d", c), {act0[30:24], 24'd0}, '0);
        end
        check("late_mem_30", {23'd0, mem0[8'h30]}, {23'd0, 8'h77});
        check("late_mem_31", {23'd0, mem0[8'h31]}, {23'd0, 8'h00});
        check("late_mem_10", {23'd0, mem0[8'h10]}, {23'd0, 8'h5A});

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, fail_count);
        $finish;
    end

endmodule
